// File: rtl/truncador_sat_pwm_pkg.sv
// ---------------------------------------------------------------------------
// truncador_sat_pwm_pkg
// Shared definitions for the saturating rescaler:
//   - round_mode_e : run-time rounding selector encodings
//   - sat_max/sat_min : saturation limits of a signed OUT_W-bit word
// ---------------------------------------------------------------------------
package truncador_sat_pwm_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'b00,  // floor
    RND_HALFUP    = 2'b01,  // round half up
    RND_CONV      = 2'b10,  // round half to even
    RND_TRUNC_ALT = 2'b11   // behaves as floor
  } round_mode_e;

  // Largest value representable in a signed out_w-bit word.
  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed out_w-bit word.
  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/redondeo_lsb.sv
// ---------------------------------------------------------------------------
// redondeo_lsb
// Purely combinational stage-1 rounding: drops SHIFT LSBs from a signed
// sample and adds the rounding increment chosen by i_round_mode.
// Ports:
//   i_dato       in  IN_W          signed sample
//   i_round_mode in  2             rounding mode (see round_mode_e)
//   o_rounded    out IN_W-SHIFT+1  rounded quotient, one guard bit wide
// ---------------------------------------------------------------------------
module redondeo_lsb
  import truncador_sat_pwm_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 6
) (
  input  logic signed [IN_W-1:0]    i_dato,
  input  logic        [1:0]         i_round_mode,
  output logic signed [IN_W-SHIFT:0] o_rounded
);

  localparam int Q_W = IN_W - SHIFT;
  // Remainder pattern that represents exactly one half LSB of the result.
  localparam logic [SHIFT-1:0] HALF = SHIFT'(1 << (SHIFT - 1));

  // Taking the upper bits of a two's complement word is an arithmetic
  // shift right, i.e. floor division by 2^SHIFT.
  logic signed [Q_W-1:0]   w_q;
  logic        [SHIFT-1:0] w_r;
  logic                    w_inc;

  assign w_q = i_dato[IN_W-1:SHIFT];
  assign w_r = i_dato[SHIFT-1:0];

  always_comb begin
    w_inc = 1'b0;
    case (round_mode_e'(i_round_mode))
      RND_HALFUP: w_inc = (w_r >= HALF);
      // Exact ties go to the even neighbour, so only an odd q is bumped.
      RND_CONV:   w_inc = (w_r > HALF) || ((w_r == HALF) && w_q[0]);
      default:    w_inc = 1'b0;
    endcase
  end

  // The extra sign bit keeps +1 on the largest quotient from wrapping.
  assign o_rounded = {w_q[Q_W-1], w_q} + {{Q_W{1'b0}}, w_inc};

endmodule

// File: rtl/truncador_sat_pwm.sv
// ---------------------------------------------------------------------------
// truncador_sat_pwm
// Two-stage registered saturating rescaler between the control filter and
// the PWM generator. Stage 1 drops SHIFT LSBs with run-time rounding, stage 2
// saturates to OUT_W bits and optionally converts to offset binary. Sticky
// overflow/underflow flags and a saturating event counter aid tuning.
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      dato_in valid this cycle
//   dato_in    in   IN_W   signed filter sample
//   round_mode in   2      00 floor, 01 half up, 10 half to even, 11 floor
//   clr_stat   in   1      synchronous clear of flags and counter
//   out_valid  out  1      dato_out valid
//   dato_out   out  OUT_W  rescaled, saturated sample
//   sat_now    out  1      sample on dato_out was saturated
//   ovf_sticky out  1      positive saturation seen since last clear
//   unf_sticky out  1      negative saturation seen since last clear
//   sat_count  out  CNT_W  saturated sample count, holds at all-ones
// ---------------------------------------------------------------------------
module truncador_sat_pwm
  import truncador_sat_pwm_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 6,
  parameter int OFFSET_BIN = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  dato_in,
  input  logic        [1:0]       round_mode,
  input  logic                    clr_stat,
  output logic                    out_valid,
  output logic        [OUT_W-1:0] dato_out,
  output logic                    sat_now,
  output logic                    ovf_sticky,
  output logic                    unf_sticky,
  output logic        [CNT_W-1:0] sat_count
);

  localparam int S1_W = IN_W - SHIFT + 1;
  localparam logic signed [S1_W-1:0] SAT_MAX_S1 = S1_W'(sat_max(OUT_W));
  localparam logic signed [S1_W-1:0] SAT_MIN_S1 = S1_W'(sat_min(OUT_W));
  localparam logic [OUT_W-1:0] CODE_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] CODE_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  // In offset binary the signed zero maps to 100..0.
  localparam logic [OUT_W-1:0] RST_CODE = (OFFSET_BIN != 0) ? CODE_MIN : '0;

  generate
    if ((SHIFT < 1) || (SHIFT > IN_W - OUT_W)) begin : g_bad_shift
      $error("truncador_sat_pwm: SHIFT=%0d outside 1..%0d", SHIFT, IN_W - OUT_W);
    end
  endgenerate

  // ---------------- stage 1: rounding ----------------
  logic signed [S1_W-1:0] w_rounded;
  logic signed [S1_W-1:0] r_s1_val;
  logic                   r_s1_valid;

  redondeo_lsb #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_redondeo (
    .i_dato       (dato_in),
    .i_round_mode (round_mode),
    .o_rounded    (w_rounded)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_val <= w_rounded;
      end
    end
  end

  // ---------------- stage 2: saturation ----------------
  logic             w_ovf;
  logic             w_unf;
  logic             w_sat;
  logic [OUT_W-1:0] w_sat_val;
  logic [OUT_W-1:0] w_code;

  assign w_ovf = (r_s1_val > SAT_MAX_S1);
  assign w_unf = (r_s1_val < SAT_MIN_S1);
  assign w_sat = w_ovf | w_unf;

  always_comb begin
    w_sat_val = r_s1_val[OUT_W-1:0];
    if (w_ovf) begin
      w_sat_val = CODE_MAX;
    end else if (w_unf) begin
      w_sat_val = CODE_MIN;
    end
    w_code = w_sat_val;
    if (OFFSET_BIN != 0) begin
      w_code[OUT_W-1] = ~w_sat_val[OUT_W-1];
    end
  end

  logic             r_out_valid;
  logic [OUT_W-1:0] r_dato_out;
  logic             r_sat_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_dato_out  <= RST_CODE;
      r_sat_now   <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dato_out <= w_code;
        r_sat_now  <= w_sat;
      end
    end
  end

  // ---------------- statistics ----------------
  logic             r_ovf;
  logic             r_unf;
  logic [CNT_W-1:0] r_sat_count;
  logic             w_event;

  assign w_event = r_s1_valid & w_sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_sat_count <= '0;
    end else if (w_event) begin
      // A saturation arriving together with a clear is still recorded.
      if (clr_stat) begin
        r_ovf       <= w_ovf;
        r_unf       <= w_unf;
        r_sat_count <= CNT_W'(1);
      end else begin
        r_ovf <= r_ovf | w_ovf;
        r_unf <= r_unf | w_unf;
        if (r_sat_count != {CNT_W{1'b1}}) begin
          r_sat_count <= r_sat_count + 1'b1;
        end
      end
    end else if (clr_stat) begin
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_sat_count <= '0;
    end
  end

  assign out_valid  = r_out_valid;
  assign dato_out   = r_dato_out;
  assign sat_now    = r_sat_now;
  assign ovf_sticky = r_ovf;
  assign unf_sticky = r_unf;
  assign sat_count  = r_sat_count;

endmodule
